// File: rtl/arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the counter-width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Width of a counter that can hold the values 0..w.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, purely combinational.
// Shared building block for the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder/subtractor built around a single full-adder cell.
// Start/busy/done handshake; result, carry-out and signed overflow are held until the next op.
module serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned CW = cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e state_q, state_d;

    logic [W-1:0]  opa_q, opb_q, res_q;
    logic          c_q;
    logic [CW-1:0] n_q;
    logic [W-1:0]  sum_q;
    logic          cout_q, ovf_q;

    logic fa_s, fa_c;
    logic accept, last_step;

    full_adder u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign accept    = (state_q == IDLE) && start;
    assign last_step = (state_q == RUN) && (n_q == LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (n_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
            n_q   <= '0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert B and force the initial carry.
            opa_q <= a;
            opb_q <= sub ? ~b : b;
            c_q   <= sub ? 1'b1 : cin;
            n_q   <= '0;
            res_q <= '0;
        end else if (state_q == RUN) begin
            opa_q <= opa_q >> 1;
            opb_q <= opb_q >> 1;
            c_q   <= fa_c;
            res_q <= {fa_s, res_q[W-1:1]};
            n_q   <= n_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_step) begin
            // On the MSB step c_q is the carry into the MSB, fa_c the carry out of it.
            sum_q  <= {fa_s, res_q[W-1:1]};
            cout_q <= fa_c;
            ovf_q  <= c_q ^ fa_c;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at W=8 and W=16: latency, handshake, results, reset abort.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;

    logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, sub16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_adder #(.W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .sub   (sub16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16),
        .ovf   (ovf16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input bit w16);
        return w16 ? done16 : done8;
    endfunction

    function automatic logic get_busy(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction

    // Issue one op on the current negedge and follow it to completion.
    // inj > 0 pulses a conflicting start on the W=8 unit that many cycles into the op.
    task automatic run_op(input bit w16, input logic s, input logic [15:0] ia, input logic [15:0] ib,
                          input logic ci, input logic [15:0] es, input logic ec, input logic eo,
                          input int inj, input string tag);
        int w;
        int cyc;
        int bcnt;
        w = w16 ? 16 : 8;
        if (w16) begin
            start16 = 1'b1; sub16 = s; a16 = ia; b16 = ib; cin16 = ci;
        end else begin
            start8 = 1'b1; sub8 = s; a8 = ia[7:0]; b8 = ib[7:0]; cin8 = ci;
        end
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16; cin8 = ~cin8; cin16 = ~cin16;
        cyc  = 1;
        bcnt = 0;
        while (!get_done(w16) && cyc < 40) begin
            if (get_busy(w16)) bcnt++;
            if (cyc == inj && !w16) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = ~sub8;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        check({tag, " latency"}, cyc, w + 1);
        check({tag, " busy_cycles"}, bcnt, w);
        check({tag, " sum"}, w16 ? {16'h0, sum16} : {24'h0, sum8}, {16'h0, es});
        check({tag, " cout"}, w16 ? cout16 : cout8, ec);
        check({tag, " ovf"}, w16 ? ovf16 : ovf8, eo);
        check({tag, " busy_at_done"}, get_busy(w16), 0);
        @(negedge clk);
        check({tag, " done_pulse_end"}, get_done(w16), 0);
        check({tag, " sum_held"}, w16 ? {16'h0, sum16} : {24'h0, sum8}, {16'h0, es});
    endtask

    initial begin
        logic [7:0] ra, rb, rbb, rs;
        logic       rsub, rcin, rc, rovf;
        logic [8:0] full;
        int         seen;

        rst_n = 1'b0;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        start16 = 0; sub16 = 0; cin16 = 0; a16 = 0; b16 = 0;
        #12;
        check("reset busy8", busy8, 0);
        check("reset done8", done8, 0);
        check("reset sum8", sum8, 0);
        check("reset cout8", cout8, 0);
        check("reset ovf8", ovf8, 0);
        check("reset busy16", busy16, 0);
        check("reset sum16", sum16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 0, 16'h5A, 16'h3C, 0, 16'h96, 0, 1, 0, "add_5a_3c");
        run_op(0, 0, 16'hFF, 16'h01, 0, 16'h00, 1, 0, 0, "add_ff_01");
        run_op(0, 0, 16'hFF, 16'h01, 1, 16'h01, 1, 0, 0, "add_ff_01_cin");
        run_op(0, 1, 16'h10, 16'h20, 0, 16'hF0, 0, 0, 0, "sub_10_20");
        run_op(0, 1, 16'h80, 16'h01, 0, 16'h7F, 1, 1, 0, "sub_80_01");
        // Conflicting start 3 cycles in is ignored; next op starts in the first IDLE cycle.
        run_op(0, 0, 16'h5A, 16'h3C, 0, 16'h96, 0, 1, 3, "ignored_start");
        run_op(0, 0, 16'h07, 16'h09, 0, 16'h10, 0, 0, 0, "back_to_back");

        // Reset abort mid-run.
        start8 = 1'b1; sub8 = 0; a8 = 8'h33; b8 = 8'h44; cin8 = 0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort busy_before", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy8, 0);
        check("abort done", done8, 0);
        check("abort sum", sum8, 0);
        check("abort cout", cout8, 0);
        check("abort ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        check("abort no_done", seen, 0);
        run_op(0, 0, 16'h01, 16'h01, 0, 16'h02, 0, 0, 0, "after_abort");

        run_op(1, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0, "w16_ffff_0001");
        run_op(1, 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1, 0, "w16_sub_8000_0001");

        for (int i = 0; i < 8; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rsub = 1'($urandom);
            rcin = 1'($urandom);
            rbb  = rsub ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, rbb} + {8'h0, (rsub ? 1'b1 : rcin)};
            rs   = full[7:0];
            rc   = full[8];
            rovf = (ra[7] == rbb[7]) && (rs[7] != ra[7]);
            run_op(0, rsub, {8'h0, ra}, {8'h0, rb}, rcin, {8'h0, rs}, rc, rovf, 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor. Computes a W-bit sum or difference, one bit per clock, using a single full-adder cell.
- Start/busy/done handshake for use as a small-area arithmetic unit in sequential datapaths.
- Generalises the existing combinational adder cells. Adds operand width, carry-in, subtract mode, signed overflow, and a registered, held result.

Parameters:
- W, 8, operand/result width in bits; legal range W >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored); sampled with start
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- cin  input  1  carry-in for add mode; sampled with start
- busy  output  1  high while the bit-serial computation runs
- done  output  1  one-cycle pulse when sum/cout/ovf become valid
- sum  output  W  result, held until the next accepted start
- cout  output  1  final carry-out (sub mode: 1 = no borrow)
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, cout, ovf = 0; sum = 0; internal shift registers, carry and counter = 0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k is accepted.
  - Latch opA=a and opB = sub ? ~b : b.
  - Carry c = sub ? 1 : cin.
  - Clear bit counter n=0 (width $clog2(W+1)) and the result shift register.
  - Go to RUN.
- RUN: each edge computes one bit through the full-adder cell.
  - s = opA[0]^opB[0]^c; c' = maj(opA[0],opB[0],c).
  - Shift opA and opB right; shift s into the result MSB; n++.
  - At the step where n==W-1, capture c (carry into MSB) for ovf.
  - After W steps (edges k+1..k+W) go to DONE.
- DONE (one cycle, after edge k+W): done=1. Return to IDLE on the next edge.
  - sum, cout and ovf are registered on the edge entering DONE.
  - They hold until the next accepted start, and are not cleared by returning to IDLE.
- busy = (state==RUN). It is high for exactly W cycles.
- Latency: start sampled at edge k, done high during the cycle after edge k+W. Total W+1 cycles.
- start while busy or in DONE: ignored; no queuing. Back-to-back operation is possible by asserting start in the first IDLE cycle.
- a, b, cin, sub may change freely after the accepting edge.
- Arithmetic: unsigned result = (a + b + cin) mod 2^W, cout = bit W. Sub mode: a + ~b + 1.

Decomposition:
- Shared package (arith_pkg): state enum {IDLE, RUN, DONE}; a CNT_W function/constant computing $clog2(W+1).
- Sub-module: full_adder (a, b, cin -> s, cout), purely combinational. Instantiated once inside serial_adder.
- FSM, shifters and counter live in the top.

Test Plan:
- W=8, add, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, ovf=1. busy high exactly 8 cycles; done one pulse 9 cycles after the start edge.
- W=8, add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Repeat with cin=1 -> sum=0x01, cout=1.
- W=8, sub, a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. Sub, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Start pulsed again with different operands 3 cycles into RUN -> ignored; the original result is delivered and busy timing is unchanged. The new start in the first IDLE cycle after done is accepted.
- rst_n low for 1 cycle mid-RUN -> busy/done/sum/cout/ovf immediately 0, no done pulse. The next op a=0x01, b=0x01 gives sum=0x02.
- Re-parametrise W=16: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, busy 16 cycles. Also a random sweep against a behavioural a+b reference model.
